// File: rtl/inst_encoder_if.sv
// Request/response bundle for inst_encoder.
//   slave  : encoder side (takes requests, drives the word stream)
//   master : producer/sink side (drives requests, consumes words)
// Request : in_valid/in_ready handshake with in_fmt, in_opcode, in_funct3,
//           in_funct7, in_rd, in_rs1, in_rs2, in_imm, in_li
// Response: out_valid/out_ready handshake with out_inst, out_addr; err pulse
interface inst_encoder_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              in_li;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic              err;

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, in_li, out_ready,
    output in_ready, out_valid, out_inst, out_addr, err
  );

  modport master (
    output in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, in_li, out_ready,
    input  in_ready, out_valid, out_inst, out_addr, err
  );
endinterface

// File: rtl/inst_encoder.sv
// inst_encoder: builds RV32I instruction words from field-level requests and
// streams them out with an instruction-memory word address. An LI pseudo-op
// expands into ADDI, LUI, or LUI followed by ADDI.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous reset, active-high
//   bus  : inst_encoder_if.slave (request handshake, output word stream, err)
// Parameters:
//   ADDR_W    : width of out_addr
//   BASE_ADDR : address of the first emitted word (4-byte aligned)
// Format codes on in_fmt: R=0 I=1 S=2 B=3 U=4 J=5.
// Optional build macro ENCODER_RANGE_CHECK_EN: reject requests whose immediate
// does not fit the selected format (err pulse, nothing emitted). Without it
// out-of-range bits are truncated and err is held 0.
module inst_encoder #(
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
  input  logic           clk,
  input  logic           rst,
  inst_encoder_if.slave  bus
);

  localparam logic [2:0] TYPE_R = 3'd0;
  localparam logic [2:0] TYPE_I = 3'd1;
  localparam logic [2:0] TYPE_S = 3'd2;
  localparam logic [2:0] TYPE_B = 3'd3;
  localparam logic [2:0] TYPE_U = 3'd4;
  localparam logic [2:0] TYPE_J = 3'd5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  typedef enum logic [0:0] {IDLE, LI_LO} state_t;

  state_t            state, state_nxt;
  logic              out_valid_q;
  logic [31:0]       out_inst_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [ADDR_W-1:0] next_addr_q;
  logic [4:0]        li_rd_q;
  logic [11:0]       li_lo_q;

  logic              accept, drain, ready;
  logic              load;
  logic [31:0]       load_word;
  logic [31:0]       enc_word;
  logic [31:0]       li_sum;
  logic              li_small, li_lui_only;
  logic              is_shift;
  logic              range_bad;

  logic [31:0] imm;
  assign imm = bus.in_imm;

  assign ready  = (state == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept = bus.in_valid && ready;
  assign drain  = out_valid_q && bus.out_ready;

  // Immediate-form shifts carry funct7 in the top bits with shamt below it.
  assign is_shift = (bus.in_opcode == OP_IMM) &&
                    ((bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b101));

  always_comb begin
    enc_word = '0;
    case (bus.in_fmt)
      TYPE_R: enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                          bus.in_rd, bus.in_opcode};
      TYPE_I: enc_word = is_shift ?
                         {bus.in_funct7, imm[4:0], bus.in_rs1, bus.in_funct3,
                          bus.in_rd, bus.in_opcode} :
                         {imm[11:0], bus.in_rs1, bus.in_funct3,
                          bus.in_rd, bus.in_opcode};
      TYPE_S: enc_word = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                          imm[4:0], bus.in_opcode};
      TYPE_B: enc_word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1,
                          bus.in_funct3, imm[4:1], imm[11], bus.in_opcode};
      TYPE_U: enc_word = {imm[31:12], bus.in_rd, bus.in_opcode};
      TYPE_J: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12],
                          bus.in_rd, bus.in_opcode};
      default: enc_word = '0;
    endcase
  end

`ifdef ENCODER_RANGE_CHECK_EN
  logic err_q;

  always_comb begin
    range_bad = 1'b0;
    if (!bus.in_li) begin
      case (bus.in_fmt)
        TYPE_I, TYPE_S: range_bad = !((&imm[31:11]) || !(|imm[31:11]));
        TYPE_B: range_bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
        TYPE_J: range_bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
        TYPE_U: range_bad = |imm[11:0];
        default: range_bad = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= accept && range_bad;
  end

  assign bus.err = err_q;
`else
  assign range_bad = 1'b0;
  assign bus.err   = 1'b0;
`endif

  // LUI takes the rounded upper part so the sign-extended ADDI low part
  // lands on the exact value.
  assign li_sum      = imm + 32'h0000_0800;
  assign li_small    = (&imm[31:11]) || !(|imm[31:11]);
  assign li_lui_only = (imm[11:0] == 12'h000);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_word = '0;
    case (state)
      IDLE: begin
        if (accept && !range_bad) begin
          load = 1'b1;
          if (!bus.in_li) begin
            load_word = enc_word;
          end else if (li_small) begin
            load_word = {imm[11:0], 5'd0, 3'b000, bus.in_rd, OP_IMM};
          end else if (li_lui_only) begin
            load_word = {imm[31:12], bus.in_rd, OP_LUI};
          end else begin
            load_word = {li_sum[31:12], bus.in_rd, OP_LUI};
            state_nxt = LI_LO;
          end
        end
      end
      LI_LO: begin
        if (drain) begin
          load      = 1'b1;
          load_word = {li_lo_q, li_rd_q, 3'b000, li_rd_q, OP_IMM};
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next_addr_q is the address for the next load; a same-cycle drain means
  // the new word goes directly after the one leaving.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_addr_q  <= BASE_ADDR;
      next_addr_q <= BASE_ADDR;
      li_rd_q     <= '0;
      li_lo_q     <= '0;
    end else begin
      if (load) begin
        out_valid_q <= 1'b1;
        out_inst_q  <= load_word;
        out_addr_q  <= drain ? out_addr_q + ADDR_W'(4) : next_addr_q;
      end else if (drain) begin
        out_valid_q <= 1'b0;
      end
      if (drain) next_addr_q <= out_addr_q + ADDR_W'(4);
      if (accept && bus.in_li) begin
        li_rd_q <= bus.in_rd;
        li_lo_q <= imm[11:0];
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_inst  = out_inst_q;
  assign bus.out_addr  = out_addr_q;

endmodule
